// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC register, direct-mapped 1-word-per-line I-cache,
// single outstanding refill request to the memory controller, ROB redirect.
module inst_fetcher #(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned ADDR_BITS  = 18,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rob_misbranch,
    input  logic [31:0] in_rob_newpc,
    input  logic        in_stall,
    output logic        out_inst_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_mem_ce,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ce,
    input  logic [31:0] in_mem_data
);

    localparam int unsigned Lines   = 2 ** INDEX_BITS;
    localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic [Lines-1:0]   valid_q;
    logic [TagBits-1:0] tag_q  [Lines];
    logic [31:0]        data_q [Lines];

    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        mem_ce_q, mem_ce_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic [INDEX_BITS-1:0] pc_idx, fill_idx;
    logic [TagBits-1:0]    pc_tag, fill_tag;
    logic                  hit;
    logic                  fill_en;

    assign pc_idx   = pc_q[INDEX_BITS+1:2];
    assign pc_tag   = pc_q[ADDR_BITS-1:INDEX_BITS+2];
    // The refill target is the held request address, not the current PC:
    // a misbranch may have moved the PC in the very cycle the word arrives.
    assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];

    assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign fill_en  = rdy && (state_q == StWaitMem) && in_mem_ce;

    // Next-state and registered-output logic; misbranch > response > lookup.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        pc_out_d     = pc_out_q;
        mem_ce_d     = 1'b0;
        mem_addr_d   = mem_addr_q;

        if (in_rob_misbranch) begin
            pc_d    = in_rob_newpc;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StWaitMem: begin
                    if (in_mem_ce) begin
                        state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (hit) begin
                        if (!in_stall) begin
                            inst_valid_d = 1'b1;
                            inst_d       = data_q[pc_idx];
                            pc_out_d     = pc_q;
                            pc_d         = pc_q + 32'd4;
                        end
                    end else begin
                        // Miss request goes out even while downstream stalls.
                        mem_ce_d   = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = StWaitMem;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control state and outputs; everything frozen while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            pc_out_q     <= 32'h0;
            mem_ce_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
        end else if (rdy) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            pc_out_q     <= pc_out_d;
            mem_ce_q     <= mem_ce_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Line valid bits; only these need clearing on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written on refill (conflicts simply overwrite).
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= in_mem_data;
        end
    end

    assign out_inst_valid = inst_valid_q;
    assign out_inst       = inst_q;
    assign out_pc         = pc_out_q;
    assign out_mem_ce     = mem_ce_q;
    assign out_mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Self-checking bench for inst_fetcher: per-cycle vector table for streaming,
// hand sequences for refill, redirect, aliasing, freeze and async reset,
// and a queue scoreboard for every emitted instruction.
module tb_inst_fetcher;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        in_rob_misbranch;
    logic [31:0] in_rob_newpc;
    logic        in_stall;
    logic        out_inst_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_mem_ce;
    logic [31:0] out_mem_addr;
    logic        in_mem_ce;
    logic [31:0] in_mem_data;

    inst_fetcher dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .in_rob_misbranch (in_rob_misbranch),
        .in_rob_newpc     (in_rob_newpc),
        .in_stall         (in_stall),
        .out_inst_valid   (out_inst_valid),
        .out_inst         (out_inst),
        .out_pc           (out_pc),
        .out_mem_ce       (out_mem_ce),
        .out_mem_addr     (out_mem_addr),
        .in_mem_ce        (in_mem_ce),
        .in_mem_data      (in_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } emit_t;

    typedef struct {
        logic        mis;
        logic [31:0] newpc;
        logic        stall;
        logic        ev;
        logic [31:0] epc;
        logic        ece;
        logic [31:0] eaddr;
    } vec_t;

    emit_t exp_q[$];
    vec_t  vecs[15];
    int    n_vec = 0;
    int    n_err = 0;

    // Memory contents seen by the fetcher.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_emit(input logic [31:0] pc);
        emit_t e;
        e.pc   = pc;
        e.inst = model_word(pc);
        exp_q.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge. An emission
    // counts only if the edge that produced it was enabled.
    task automatic tick();
        logic  was_rdy;
        emit_t e;
        was_rdy = rdy;
        @(posedge clk);
        #1;
        if (was_rdy && out_inst_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_emit: got pc %h want no emission", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("emit_pc", out_pc, e.pc);
                check("emit_inst", out_inst, e.inst);
            end
        end
    endtask

    task automatic mem_respond(input logic [31:0] addr);
        in_mem_ce   = 1'b1;
        in_mem_data = model_word(addr);
        tick();
        in_mem_ce   = 1'b0;
        in_mem_data = 32'h0;
    endtask

    // From WAIT_MEM on addr: refill, emit it, then expect the miss on addr+4.
    task automatic fetch_line(input logic [31:0] addr);
        check("req_addr", out_mem_addr, addr);
        expect_emit(addr);
        mem_respond(addr);
        check("refill_valid", 32'(out_inst_valid), 32'd0);
        tick();
        check("emit_valid", 32'(out_inst_valid), 32'd1);
        tick();
        check("next_req_ce", 32'(out_mem_ce), 32'd1);
        check("next_req_addr", out_mem_addr, addr + 32'd4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_inst_valid), 32'd0);
        check({tag, "_inst"}, out_inst, 32'd0);
        check({tag, "_pc"}, out_pc, 32'd0);
        check({tag, "_mem_ce"}, 32'(out_mem_ce), 32'd0);
        check({tag, "_mem_addr"}, out_mem_addr, 32'd0);
    endtask

    initial begin
        //          mis   newpc   stall ev    epc      ece   eaddr
        vecs[0]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0C, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h14};
        vecs[14] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0};

        rst              = 1'b1;
        rdy              = 1'b1;
        in_rob_misbranch = 1'b0;
        in_rob_newpc     = 32'h0;
        in_stall         = 1'b0;
        in_mem_ce        = 1'b0;
        in_mem_data      = 32'h0;
        #2 rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // Cold start: exactly one request for address 0.
        rst = 1'b1;
        tick();
        check("cold_ce", 32'(out_mem_ce), 32'd1);
        check("cold_addr", out_mem_addr, 32'h0);
        check("cold_valid", 32'(out_inst_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_ce_low", 32'(out_mem_ce), 32'd0);
            check("wait_addr_held", out_mem_addr, 32'h0);
        end

        // Refill 0x0..0xC through the miss path.
        fetch_line(32'h0);
        fetch_line(32'h4);
        fetch_line(32'h8);
        fetch_line(32'hC);

        // Redirect while waiting on 0x10; the word arriving the same cycle is
        // cached but not issued.
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = 32'h100;
        in_mem_ce        = 1'b1;
        in_mem_data      = model_word(32'h10);
        tick();
        in_rob_misbranch = 1'b0;
        in_mem_ce        = 1'b0;
        check("mb_valid", 32'(out_inst_valid), 32'd0);
        check("mb_ce", 32'(out_mem_ce), 32'd0);
        tick();
        check("mb_new_ce", 32'(out_mem_ce), 32'd1);
        check("mb_new_addr", out_mem_addr, 32'h100);
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = 32'h0;
        tick();
        in_rob_misbranch = 1'b0;
        check("mb2_valid", 32'(out_inst_valid), 32'd0);
        check("mb2_ce", 32'(out_mem_ce), 32'd0);

        // Hit streaming with stalls, redirect and a stalled miss.
        for (int i = 0; i < 15; i++) begin
            in_rob_misbranch = vecs[i].mis;
            in_rob_newpc     = vecs[i].newpc;
            in_stall         = vecs[i].stall;
            if (vecs[i].ev) expect_emit(vecs[i].epc);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(out_inst_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_ce", i), 32'(out_mem_ce), 32'(vecs[i].ece));
            if (vecs[i].ev) check($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
            if (vecs[i].ece) check($sformatf("vec%0d_addr", i), out_mem_addr, vecs[i].eaddr);
        end
        in_rob_misbranch = 1'b0;
        in_stall         = 1'b0;

        // Aliasing: 0x400 shares line 0 with 0x000.
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = 32'h400;
        tick();
        in_rob_misbranch = 1'b0;
        check("alias_mb_valid", 32'(out_inst_valid), 32'd0);
        tick();
        check("alias_miss_ce", 32'(out_mem_ce), 32'd1);
        fetch_line(32'h400);
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = 32'h0;
        tick();
        in_rob_misbranch = 1'b0;
        check("realias_mb_valid", 32'(out_inst_valid), 32'd0);
        tick();
        check("realias_miss_ce", 32'(out_mem_ce), 32'd1);
        check("realias_miss_addr", out_mem_addr, 32'h0);
        expect_emit(32'h0);
        mem_respond(32'h0);
        tick();
        check("realias_emit", 32'(out_inst_valid), 32'd1);

        // Freeze for 5 cycles; a redirect offered meanwhile must be ignored.
        rdy              = 1'b0;
        in_rob_misbranch = 1'b1;
        in_rob_newpc     = 32'h200;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_valid", 32'(out_inst_valid), 32'd1);
            check("frz_pc", out_pc, 32'h0);
            check("frz_inst", out_inst, 32'h13);
            check("frz_ce", 32'(out_mem_ce), 32'd0);
        end
        rdy              = 1'b1;
        in_rob_misbranch = 1'b0;
        for (int i = 1; i < 5; i++) begin
            expect_emit(32'(i * 4));
            tick();
            check("resume_valid", 32'(out_inst_valid), 32'd1);
        end
        tick();
        check("resume_miss_ce", 32'(out_mem_ce), 32'd1);
        check("resume_miss_addr", out_mem_addr, 32'h14);
        tick();
        check("resume_wait_ce", 32'(out_mem_ce), 32'd0);

        // Asynchronous reset in the middle of WAIT_MEM.
        #3 rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        check("rst_hold_ce", 32'(out_mem_ce), 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_ce", 32'(out_mem_ce), 32'd1);
        check("post_rst_addr", out_mem_addr, 32'h0);
        tick();
        fetch_line(32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
